// File: rtl/fan_gear_scheduler.sv
// Fan gear scheduler: press-driven target, ramped upshift, low-battery derate.
// Optional idle auto-off is built when FAN_SLEEP_TIMER_EN is defined.
module fan_gear_scheduler #(
    parameter int RAMP_TICKS  = 5,
    parameter int LOW_THRESH  = 20,
    parameter int HYST        = 5,
    parameter int SLEEP_TICKS = 600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       press,
    input  logic       tick_100ms,
    input  logic [7:0] battery,
    input  logic       charging,
    input  logic       battery_empty,
    output logic [1:0] state,
    output logic [1:0] target,
    output logic       ramping,
    output logic       derated,
    output logic       sleep_off
);

    localparam logic [7:0] RAMP_LAST = 8'(RAMP_TICKS - 1);
    localparam logic [7:0] LOW_LVL   = 8'(LOW_THRESH);
    localparam logic [7:0] REL_LVL   = 8'(LOW_THRESH + HYST);

    typedef enum logic [1:0] {
        G_OFF,
        G_RAMP,
        G_HOLD,
        G_DROP
    } gear_mode_t;

    function automatic logic [1:0] eff_of(
        input logic [1:0] tgt,
        input logic       der,
        input logic       empty
    );
        logic [1:0] e;
        if (empty)
            e = 2'd0;
        else if (der)
            e = (tgt != 2'd0) ? 2'd1 : 2'd0;
        else
            e = tgt;
        return e;
    endfunction

    gear_mode_t mode;
    logic [7:0] ramp_cnt;
    logic [1:0] eff;
    logic [1:0] eff_prev;
    logic [1:0] eff_nxt;
    logic [1:0] target_nxt;
    logic [1:0] state_nxt;
    logic       derated_nxt;
    logic       press_ok;
    logic       sleep_fire;
    logic       ramp_clr;
    logic       ramp_step;

    always_comb begin
        eff = eff_of(target, derated, battery_empty);
        if (state > eff)
            mode = G_DROP;
        else if (state < eff)
            mode = G_RAMP;
        else if (state == 2'd0)
            mode = G_OFF;
        else
            mode = G_HOLD;
    end

    always_comb begin
        press_ok = press && !battery_empty && !sleep_fire;
        if (battery_empty || sleep_fire)
            target_nxt = 2'd0;
        else if (press_ok)
            target_nxt = target + 2'd1;
        else
            target_nxt = target;

        if (charging || battery >= REL_LVL)
            derated_nxt = 1'b0;
        else if (battery < LOW_LVL)
            derated_nxt = 1'b1;
        else
            derated_nxt = derated;

        eff_nxt = eff_of(target_nxt, derated_nxt, battery_empty);
    end

    // Any target/cap change or higher-priority event restarts the step interval.
    always_comb begin
        ramp_clr = (mode != G_RAMP) || (eff != eff_prev) || press_ok
                || sleep_fire || battery_empty;
        ramp_step = !ramp_clr && tick_100ms && (ramp_cnt == RAMP_LAST);
        unique case (mode)
            G_DROP:  state_nxt = eff;
            G_RAMP:  state_nxt = ramp_step ? state + 2'd1 : state;
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= 2'd0;
            target   <= 2'd0;
            ramping  <= 1'b0;
            derated  <= 1'b0;
            eff_prev <= 2'd0;
            ramp_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            target   <= target_nxt;
            ramping  <= state_nxt < eff_nxt;
            derated  <= derated_nxt;
            eff_prev <= eff;
            if (ramp_clr || ramp_step)
                ramp_cnt <= 8'd0;
            else if (tick_100ms)
                ramp_cnt <= ramp_cnt + 8'd1;
        end
    end

`ifdef FAN_SLEEP_TIMER_EN
    localparam logic [15:0] SLEEP_LAST = 16'(SLEEP_TICKS - 1);

    logic [15:0] idle_cnt;

    assign sleep_fire = !battery_empty && (state != 2'd0) && tick_100ms
                     && (idle_cnt == SLEEP_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt  <= 16'd0;
            sleep_off <= 1'b0;
        end else begin
            sleep_off <= sleep_fire;
            if (state == 2'd0 || press || sleep_fire)
                idle_cnt <= 16'd0;
            else if (tick_100ms)
                idle_cnt <= idle_cnt + 16'd1;
        end
    end
`else
    assign sleep_fire = 1'b0;
    // SLEEP_TICKS is at least 1, so this is a constant 0.
    assign sleep_off = (SLEEP_TICKS == 0);
`endif

endmodule

// File: tb/tb_fan_gear_scheduler.sv
// Directed bench for fan_gear_scheduler: ramp, drop, derate, empty, reset.
// Sleep checks follow FAN_SLEEP_TIMER_EN.
module tb_fan_gear_scheduler;

    logic       clk;
    logic       reset;
    logic       press;
    logic       tick_100ms;
    logic [7:0] battery;
    logic       charging;
    logic       battery_empty;
    logic [1:0] state;
    logic [1:0] target;
    logic       ramping;
    logic       derated;
    logic       sleep_off;

    int n_chk;
    int n_err;
    int phase;
    int ticks_seen;

    fan_gear_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .press         (press),
        .tick_100ms    (tick_100ms),
        .battery       (battery),
        .charging      (charging),
        .battery_empty (battery_empty),
        .state         (state),
        .target        (target),
        .ramping       (ramping),
        .derated       (derated),
        .sleep_off     (sleep_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock; strobe every 10th cycle; outputs sampled 1 ns after the edge.
    task automatic step();
        tick_100ms = (phase == 9);
        @(posedge clk);
        #1;
        if (tick_100ms)
            ticks_seen++;
        phase = (phase + 1) % 10;
        tick_100ms = 1'b0;
        press = 1'b0;
    endtask

    task automatic do_press();
        press = 1'b1;
        step();
    endtask

    task automatic align();
        while (phase != 0)
            step();
    endtask

    task automatic wait_ticks(input int n);
        int k;
        k = 0;
        while (ticks_seen < n && k < 20000) begin
            step();
            k++;
        end
        if (ticks_seen < n)
            check("tick_timeout", ticks_seen, n);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        phase = 0;
        ticks_seen = 0;
        reset = 1'b1;
        press = 1'b0;
        tick_100ms = 1'b0;
        battery = 8'd80;
        charging = 1'b0;
        battery_empty = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", state, 0);
        check("rst_target", target, 0);
        check("rst_ramping", ramping, 0);
        check("rst_derated", derated, 0);
        check("rst_sleep", sleep_off, 0);
        reset = 1'b0;
        phase = 0;

        // Ramp up 0 -> 3
        align();
        ticks_seen = 0;
        do_press(); step(); do_press(); step(); do_press();
        check("up_target", target, 3);
        check("up_ramping_on", ramping, 1);
        check("up_state0", state, 0);
        wait_ticks(4);
        check("up_before5", state, 0);
        wait_ticks(5);
        check("up_s1", state, 1);
        check("up_ramping_mid", ramping, 1);
        wait_ticks(9);
        check("up_before10", state, 1);
        wait_ticks(10);
        check("up_s2", state, 2);
        wait_ticks(15);
        check("up_s3", state, 3);
        check("up_ramping_off", ramping, 0);

        // Immediate drop 3 -> 0
        do_press();
        check("drop_target", target, 0);
        check("drop_state_hold", state, 3);
        step();
        check("drop_state", state, 0);
        check("drop_ramping", ramping, 0);

        // Derate with hysteresis
        align();
        ticks_seen = 0;
        do_press(); step(); do_press(); step(); do_press();
        wait_ticks(15);
        check("der_pre_s3", state, 3);
        battery = 8'd19;
        step();
        check("der_set", derated, 1);
        check("der_state_lag", state, 3);
        step();
        check("der_state1", state, 1);
        battery = 8'd24;
        repeat (3) step();
        check("der_hold24", derated, 1);
        check("der_state24", state, 1);
        align();
        battery = 8'd25;
        step();
        check("der_release25", derated, 0);
        ticks_seen = 0;
        wait_ticks(4);
        check("der_rel_before5", state, 1);
        wait_ticks(5);
        check("der_rel_s2", state, 2);
        wait_ticks(10);
        check("der_rel_s3", state, 3);

        // Charging releases derate
        battery = 8'd10;
        step();
        check("chg_derated", derated, 1);
        step();
        check("chg_state1", state, 1);
        align();
        charging = 1'b1;
        step();
        check("chg_release", derated, 0);
        ticks_seen = 0;
        wait_ticks(5);
        check("chg_s2", state, 2);
        check("chg_ramping", ramping, 1);
        charging = 1'b0;
        battery = 8'd80;

        // Empty beats press
        align();
        do_press(); step(); do_press();
        check("emp_target1", target, 1);
        battery_empty = 1'b1;
        do_press();
        check("emp_target", target, 0);
        check("emp_state", state, 0);
        do_press(); step(); do_press();
        check("emp_press_ignored", target, 0);
        check("emp_ramping", ramping, 0);
        battery_empty = 1'b0;
        step();

        // Asynchronous reset mid-ramp
        align();
        ticks_seen = 0;
        do_press(); step(); do_press();
        wait_ticks(7);
        check("rr_pre_s1", state, 1);
        #2;
        reset = 1'b1;
        #1;
        check("rr_async_state", state, 0);
        check("rr_async_target", target, 0);
        check("rr_async_ramping", ramping, 0);
        step();
        reset = 1'b0;
        repeat (2) step();
        check("rr_no_resume", state, 0);

`ifdef FAN_SLEEP_TIMER_EN
        // Sleep fires after 600 idle strobes with the fan on
        align();
        ticks_seen = 0;
        do_press(); step(); do_press();
        wait_ticks(604);
        check("slp_not_yet", sleep_off, 0);
        check("slp_state2", state, 2);
        wait_ticks(605);
        check("slp_pulse", sleep_off, 1);
        check("slp_target", target, 0);
        step();
        check("slp_pulse_end", sleep_off, 0);
        check("slp_state_off", state, 0);

        // Press on the 599th counted strobe restarts the count
        align();
        ticks_seen = 0;
        do_press(); step(); do_press();
        wait_ticks(603);
        while (phase != 9)
            step();
        do_press();
        check("slp_rs_target", target, 3);
        wait_ticks(1203);
        check("slp_rs_not_yet", sleep_off, 0);
        wait_ticks(1204);
        check("slp_rs_pulse", sleep_off, 1);
        step();
        check("slp_rs_off", state, 0);
`else
        // Without the idle timer the fan keeps running
        align();
        ticks_seen = 0;
        do_press(); step(); do_press();
        wait_ticks(620);
        check("nosleep_pulse", sleep_off, 0);
        check("nosleep_state", state, 2);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fan_gear_scheduler.md
# fan_gear_scheduler

- Sits between the debounced BTN7 press pulse and the gear consumers: battery manager, LED control, dot-matrix and seven-segment display.
- Holds the user-selected target gear and ramps the applied gear toward it one step at a time.
- Caps the gear on low battery, with hysteresis, and forces off when the battery is empty.
- Optionally shuts the fan off after a period with no button presses.

## Interface
Parameters:
- RAMP_TICKS, 5 — `tick_100ms` strobes per upward gear step (500 ms); legal range 1..255.
- LOW_THRESH, 20 — battery level below which derating engages.
- HYST, 5 — derating releases at `battery >= LOW_THRESH + HYST`.
- SLEEP_TICKS, 600 — idle `tick_100ms` strobes before auto-off (60 s); legal range 1..65535.

Ports:
- clk  in  1  system clock (100 Hz in the product build); one clock domain.
- reset  in  1  asynchronous, active-high reset.
- press  in  1  single-cycle pulse from the debouncer.
- tick_100ms  in  1  single-cycle strobe from Timer.
- battery  in  8  battery level, 0..100.
- charging  in  1  SW0 charging flag.
- battery_empty  in  1  battery-exhausted flag.
- state  out  2  applied gear: 0 off, 1 low, 2 mid, 3 high.
- target  out  2  user-selected gear.
- ramping  out  1  high while `state` is below the effective target.
- derated  out  1  low-battery cap is active.
- sleep_off  out  1  one-cycle pulse when auto-off fires.

## Operation
- All outputs and internal counters reset to 0.
- **Target selection.** On `press` with `battery_empty` low, `target` advances 0→1→2→3→0, wrapping.
  - `press` is ignored while `battery_empty` is high.
  - While `battery_empty` is high, `target` is forced to 0.
- **Derating flag.**
  - `derated` sets when `battery < LOW_THRESH` and `charging == 0`.
  - `derated` clears when `battery >= LOW_THRESH + HYST` or `charging == 1`.
  - Otherwise `derated` holds its value.
- **Effective target (combinational).** `eff`:
  - 0 if `battery_empty`;
  - else `min(target, 1)` if `derated`;
  - else `target`.
- **Gear FSM.**
  - OFF: `state == 0` and `eff == 0`.
  - RAMP: `state < eff`.
  - HOLD: `state == eff != 0`.
  - DROP: `state > eff`.
    - Transient: on the next cycle `state <= eff`, then the FSM enters HOLD or OFF.
    - Downward changes are never ramped.
- **Ramp counter (8 bit).**
  - In RAMP it counts `tick_100ms` strobes.
  - On the strobe where the count equals RAMP_TICKS-1: `state` increments by 1 and the counter clears.
  - The counter clears whenever `eff` changes or the FSM leaves RAMP.
- `ramping = (state < eff)`, registered alongside `state`.
- **Simultaneous events, in priority order:** reset > `battery_empty` > sleep expiry > `press` > ramp step.
  - A press in the same cycle as a ramp-step strobe: the target update wins, the counter clears, and no step is taken.
- `state` only ever changes by +1 (ramp), or drops directly to `eff`.

## Timing
- `target` and `derated` update one cycle after the causing input.
- `state` reacts to an `eff` decrease one cycle after `eff` changes, so two cycles after a `press` or `battery` change.
- An upward step occurs on the cycle after the RAMP_TICKS-th strobe counted since entering RAMP or since the last step.
- OFF→3 therefore takes 3×RAMP_TICKS strobes, plus one cycle.
- `sleep_off` is high for exactly one cycle; `target` and `state` are 0 on the following cycle.
- Asynchronous `reset` mid-ramp clears all state immediately. There is no resume after reset.

## Configuration
- **`FAN_SLEEP_TIMER_EN` defined:**
  - A 16-bit idle counter counts `tick_100ms` strobes while `state != 0`.
  - It clears on `press`, and also while `state == 0`.
  - When the count reaches SLEEP_TICKS-1 on a strobe: `sleep_off` pulses, `target <= 0`, then DROP to OFF.
- **`FAN_SLEEP_TIMER_EN` undefined:**
  - No idle counter is built.
  - `sleep_off` is tied to 0.
  - The fan runs until a press or battery exhaustion.

## Test plan
Defaults throughout; `tick_100ms` strobes every 10 clocks; `battery = 80`; `charging = 0`.
- **Ramp up.** Three presses, 1 cycle apart →
  - `target = 3`;
  - `state` steps 1, 2, 3 at strobes 5, 10, 15;
  - `ramping` drops when `state == 3`.
- **Immediate drop.** `state = 3`, then press →
  - `target = 0`;
  - `state = 0` two cycles after the press;
  - no ramp.
- **Derate with hysteresis.** `state = 3`, `battery` goes to 19 →
  - `derated = 1`, `state = 1`;
  - `battery` at 24: still derated;
  - `battery` at 25: `derated = 0`, then ramp to 2 after 5 strobes and to 3 after 10.
- **Charging releases derate.** Derated at `battery = 10`, `charging` goes to 1 → `derated` clears next cycle and ramping resumes.
- **Empty beats press.** `battery_empty` and `press` in the same cycle at `target = 1` →
  - `target = 0`, `state = 0`;
  - presses during empty leave `target` at 0.
- **Sleep timer (`FAN_SLEEP_TIMER_EN` defined).** `state = 2`, no press →
  - `sleep_off` pulses on the cycle after the 600th strobe, then `state = 0`;
  - a press at strobe 599 restarts the count.
